window_scanner: RTL and testbench

WINDOW_SCANNER -- requirements
Module: window_scanner

---
 rtl/window_scanner.sv | 119 +++++++++++
 tb/tb_window_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_scanner.sv
// Window scanner: captures one TILE x TILE pixel tile and emits every K x K
// window of it in raster order (row-major, column fastest), one window per
// accepted transfer on the output handshake.
module window_scanner #(
    parameter int PW     = 4,
    parameter int TILE   = 4,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    localparam int N     = (TILE - K) / STRIDE + 1,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tile_valid,
    output logic                     tile_ready,
    input  logic [TILE*TILE*PW-1:0]  tile_pixels,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [K*K*PW-1:0]        win_pixels,
    output logic [IW-1:0]            win_row,
    output logic [IW-1:0]            win_col,
    output logic                     win_last,
    input  logic                     flush,
    output logic                     busy,
    output logic                     state_dbg
);

    // Handshake rule for both ports: a beat moves on a rising edge where
    // valid and ready are both high. The producer holds valid and payload
    // stable until that edge; ready may change freely. The tile port is
    // ready only in IDLE, so a tile is captured at most once per scan.

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [0:0]               state_q;
    logic [IW-1:0]            row_q;
    logic [IW-1:0]            col_q;
    logic [TILE*TILE*PW-1:0]  tile_q;

    logic                     scanning;
    logic                     at_last;
    logic                     xfer;
    logic                     tile_accept;

    assign scanning    = (state_q == S_SCAN);
    assign at_last     = scanning && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign xfer        = win_valid && win_ready;
    assign tile_accept = (state_q == S_IDLE) && tile_valid;

    // The tile port reports not-ready while reset is applied; afterwards
    // it simply follows the IDLE state.
    assign tile_ready = (state_q == S_IDLE) && !rst;
    assign win_valid  = scanning;
    assign busy       = scanning;
    assign win_last   = at_last;
    assign win_row    = row_q;
    assign win_col    = col_q;
    assign state_dbg  = state_q;

    // State, window position and tile register; flush beats a same-cycle
    // transfer, and the tile register loads only when a tile is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tile_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tile_accept) begin
                        tile_q  <= tile_pixels;
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (flush) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (xfer) begin
                        if (at_last) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= S_IDLE;
                        end else if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Window extraction: element (i,j) is tile pixel
    // (row*STRIDE+i, col*STRIDE+j), read straight from registered state so
    // the window holds steady under backpressure.
    always_comb begin
        win_pixels = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_pixels[(i*K+j)*PW +: PW] =
                    tile_q[((int'(row_q)*STRIDE + i)*TILE + int'(col_q)*STRIDE + j)*PW +: PW];
            end
        end
    end

endmodule

// File: tb/tb_window_scanner.sv
// Directed bench for window_scanner: default 4x4/3x3/stride-1 instance plus
// an 8x8/4x4/stride-2 instance.
module tb_window_scanner;

    // clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default-parameter instance
    logic         tile_valid;
    logic         tile_ready;
    logic [63:0]  tile_pixels;
    logic         win_valid;
    logic         win_ready;
    logic [35:0]  win_pixels;
    logic [0:0]   win_row;
    logic [0:0]   win_col;
    logic         win_last;
    logic         flush;
    logic         busy;
    logic         state_dbg;

    // 8x8 tile, 4x4 window, stride 2 instance
    logic         b_tile_valid;
    logic         b_tile_ready;
    logic [255:0] b_tile_pixels;
    logic         b_win_valid;
    logic         b_win_ready;
    logic [63:0]  b_win_pixels;
    logic [1:0]   b_win_row;
    logic [1:0]   b_win_col;
    logic         b_win_last;
    logic         b_flush;
    logic         b_busy;
    logic         b_state_dbg;

    int total = 0;
    int bad   = 0;

    window_scanner u_dut (
        .clk         (clk),
        .rst         (rst),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .tile_pixels (tile_pixels),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_pixels  (win_pixels),
        .win_row     (win_row),
        .win_col     (win_col),
        .win_last    (win_last),
        .flush       (flush),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    window_scanner #(.PW(4), .TILE(8), .K(4), .STRIDE(2)) u_big (
        .clk         (clk),
        .rst         (rst),
        .tile_valid  (b_tile_valid),
        .tile_ready  (b_tile_ready),
        .tile_pixels (b_tile_pixels),
        .win_valid   (b_win_valid),
        .win_ready   (b_win_ready),
        .win_pixels  (b_win_pixels),
        .win_row     (b_win_row),
        .win_col     (b_win_col),
        .win_last    (b_win_last),
        .flush       (b_flush),
        .busy        (b_busy),
        .state_dbg   (b_state_dbg)
    );

    // tiles and hand-computed windows (element 0 in the low nibble)
    localparam logic [63:0] T0  = 64'hfedcba9876543210;  // pixel p = p
    localparam logic [63:0] T1  = 64'h0123456789abcdef;  // pixel p = 15-p
    localparam logic [63:0] W00 = 64'h0000000a98654210;
    localparam logic [63:0] W01 = 64'h0000000ba9765321;
    localparam logic [63:0] W10 = 64'h0000000edca98654;
    localparam logic [63:0] W11 = 64'h0000000fedba9765;
    localparam logic [63:0] V00 = 64'h00000005679abdef;
    localparam logic [63:0] V01 = 64'h000000045689acde;
    localparam logic [63:0] V10 = 64'h00000001235679ab;
    localparam logic [63:0] V11 = 64'h000000001245689a;
    // big tile: pixel(r,c) = (3r+c) mod 16; window (2,1) in full
    localparam logic [63:0] B21 = 64'ha9877654432110fe;

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input int r, input int c,
                           input logic [63:0] pix, input logic last);
        chk({tag, ".valid"}, 64'(win_valid), 64'd1);
        chk({tag, ".row"},   64'(win_row),   64'(r));
        chk({tag, ".col"},   64'(win_col),   64'(c));
        chk({tag, ".pix"},   64'(win_pixels), pix);
        chk({tag, ".last"},  64'(win_last),  64'(last));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 64'(win_valid),  64'd0);
        chk({tag, ".ready"}, 64'(tile_ready), 64'd1);
        chk({tag, ".busy"},  64'(busy),       64'd0);
    endtask

    int e00 [9] = '{0, 2, 4, 6, 8, 10, 12, 14, 0};

    initial begin
        rst = 1'b1; tile_valid = 1'b0; tile_pixels = '0; win_ready = 1'b0; flush = 1'b0;
        b_tile_valid = 1'b0; b_tile_pixels = '0; b_win_ready = 1'b0; b_flush = 1'b0;

        // reset cycle
        smp();
        chk("rst.tile_ready", 64'(tile_ready), 64'd0);
        chk("rst.win_valid",  64'(win_valid),  64'd0);
        chk("rst.busy",       64'(busy),       64'd0);
        chk("rst.win_last",   64'(win_last),   64'd0);
        chk("rst.win_pixels", 64'(win_pixels), 64'd0);
        step();
        rst = 1'b0;
        smp();
        chk_idle("post_rst");
        chk("post_rst.win_pixels", 64'(win_pixels), 64'd0);
        step();

        // full scan of T0; tile_valid stays high with T1 during the scan
        tile_valid = 1'b1; tile_pixels = T0; win_ready = 1'b1;
        smp(); chk("a.accept_ready", 64'(tile_ready), 64'd1); step();
        tile_pixels = T1;
        smp(); chk_win("a.w00", 0, 0, W00, 1'b0);
        chk("a.scan_ready", 64'(tile_ready), 64'd0);
        chk("a.scan_busy",  64'(busy),       64'd1); step();
        smp(); chk_win("a.w01", 0, 1, W01, 1'b0); step();
        smp(); chk_win("a.w10", 1, 0, W10, 1'b0); step();
        smp(); chk_win("a.w11", 1, 1, W11, 1'b1); step();
        smp(); chk_idle("a.bubble"); step();       // T1 accepted here
        tile_valid = 1'b0;
        smp(); chk_win("a.v00", 0, 0, V00, 1'b0); step();
        smp(); chk_win("a.v01", 0, 1, V01, 1'b0); step();
        smp(); chk_win("a.v10", 1, 0, V10, 1'b0); step();
        smp(); chk_win("a.v11", 1, 1, V11, 1'b1); step();
        smp(); chk_idle("a.end"); step();

        // backpressure: hold (0,1) for three stalled cycles
        tile_valid = 1'b1; tile_pixels = T0; win_ready = 1'b1;
        smp(); chk("b.accept_ready", 64'(tile_ready), 64'd1); step();
        tile_valid = 1'b0;
        smp(); chk_win("b.w00", 0, 0, W00, 1'b0); step();
        win_ready = 1'b0;
        smp(); chk_win("b.w01_s1", 0, 1, W01, 1'b0); step();
        smp(); chk_win("b.w01_s2", 0, 1, W01, 1'b0); step();
        smp(); chk_win("b.w01_s3", 0, 1, W01, 1'b0); step();
        win_ready = 1'b1;
        smp(); chk_win("b.w01_go", 0, 1, W01, 1'b0); step();
        smp(); chk_win("b.w10", 1, 0, W10, 1'b0); step();
        smp(); chk_win("b.w11", 1, 1, W11, 1'b1); step();
        smp(); chk_idle("b.end"); step();

        // flush on (1,0) together with a transfer
        tile_valid = 1'b1; tile_pixels = T0;
        smp(); step();
        tile_valid = 1'b0;
        smp(); chk_win("c.w00", 0, 0, W00, 1'b0); step();
        smp(); chk_win("c.w01", 0, 1, W01, 1'b0); step();
        flush = 1'b1;
        smp(); chk_win("c.w10", 1, 0, W10, 1'b0); step();
        // flush in IDLE does not block a new tile
        tile_valid = 1'b1; tile_pixels = T1;
        smp(); chk_idle("c.flushed"); step();
        flush = 1'b0; tile_valid = 1'b0;
        smp(); chk_win("c.v00", 0, 0, V00, 1'b0); step();

        // reset during window (0,1) with tile_valid held high
        rst = 1'b1; tile_valid = 1'b1; tile_pixels = T0;
        smp(); chk_win("d.v01", 0, 1, V01, 1'b0);
        chk("d.rst_ready", 64'(tile_ready), 64'd0); step();
        rst = 1'b0;
        smp(); chk_idle("d.after_rst");
        chk("d.after_rst.pix", 64'(win_pixels), 64'd0); step();
        tile_valid = 1'b0;
        smp(); chk_win("d.w00", 0, 0, W00, 1'b0); step();
        smp(); chk_win("d.w01", 0, 1, W01, 1'b0); step();
        win_ready = 1'b0;

        // 8x8 tile, 4x4 windows, stride 2: nine windows in raster order
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b_tile_pixels[(r*8+c)*4 +: 4] = 4'((r*3 + c) % 16);
        b_tile_valid = 1'b1; b_win_ready = 1'b1;
        smp(); chk("e.accept_ready", 64'(b_tile_ready), 64'd1); step();
        b_tile_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            smp();
            chk("e.valid", 64'(b_win_valid), 64'd1);
            chk("e.row",   64'(b_win_row), 64'(k / 3));
            chk("e.col",   64'(b_win_col), 64'(k % 3));
            chk("e.el00",  64'(b_win_pixels[3:0]), 64'(e00[k]));
            chk("e.last",  64'(b_win_last), 64'(k == 8));
            if (k == 7) chk("e.w21", b_win_pixels, B21);
            step();
        end
        smp();
        chk("e.end_valid", 64'(b_win_valid),  64'd0);
        chk("e.end_ready", 64'(b_tile_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
